// File: rtl/fifo_flex.sv
// fifo_flex: parametrised synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty flags, sticky overflow/underflow, synchronous flush
// and a selectable read mode (show-ahead, or registered read with r_valid).
module fifo_flex #(
  parameter int B         = 8,
  parameter int W         = 4,
  parameter int AF_THRESH = 2**W - 2,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         r_valid,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow,
  input  logic         clr_err
);

  localparam int         DEPTH   = 2**W;
  localparam logic [W:0] DEPTH_C = (W+1)'(DEPTH);
  localparam logic [W:0] AF_C    = (W+1)'(AF_THRESH);
  localparam logic [W:0] AE_C    = (W+1)'(AE_THRESH);

  // Threshold sanity: both must lie inside the FIFO's occupancy range.
  if (AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_bad_thresh
    $error("fifo_flex: AF_THRESH must be <= 2**W and AE_THRESH < 2**W");
  end

  logic [B-1:0] mem [DEPTH];
  logic [W-1:0] w_ptr;
  logic [W-1:0] r_ptr;
  logic [W:0]   cnt;
  logic         wr_acc;
  logic         rd_acc;

  // Flags come only from registered occupancy, never from rd/wr.
  assign empty        = (cnt == '0);
  assign full         = (cnt == DEPTH_C);
  assign almost_empty = (cnt <= AE_C);
  assign almost_full  = (cnt >= AF_C);
  assign count        = cnt;

  // A write into a full FIFO is still taken when a pop frees a slot on the same edge.
  assign rd_acc = rd & ~empty & ~flush;
  assign wr_acc = wr & (~full | rd_acc) & ~flush;

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[w_ptr] <= w_data;
  end

  // Pointer and occupancy update; reset outranks flush.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      w_ptr <= '0;
      r_ptr <= '0;
      cnt   <= '0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + 1'b1;
      if (rd_acc) r_ptr <= r_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky error flags; clr_err wins over a same-cycle set, flush leaves them alone.
  always_ff @(posedge clk) begin
    if (reset || clr_err) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr & full & ~rd_acc & ~flush) overflow  <= 1'b1;
      if (rd & empty & ~flush)          underflow <= 1'b1;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head of queue is always on r_data; valid whenever something is stored.
    assign r_data  = mem[r_ptr];
    assign r_valid = ~empty;
  end else begin : g_reg
    logic [B-1:0] r_data_q;
    logic         r_valid_q;

    // Registered read: popped word appears one cycle after rd with a one-cycle strobe.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else begin
        r_valid_q <= rd_acc;
        if (rd_acc) r_data_q <= mem[r_ptr];
      end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
  end

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex: W=2 show-ahead instance driven from a vector
// table, plus a W=2 registered-read instance for the latency/strobe cases.
module tb_fifo_flex;

  logic       clk = 1'b0;
  logic       reset, flush, wr, rd, clr_err;
  logic [7:0] w_data;

  logic [7:0] a_rdata, b_rdata;
  logic       a_rvalid, b_rvalid;
  logic       a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
  logic       b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
  logic [2:0] a_count, b_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_flex #(.B(8), .W(2), .FWFT(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(a_rdata), .r_valid(a_rvalid), .empty(a_empty), .full(a_full),
    .almost_empty(a_ae), .almost_full(a_af), .count(a_count),
    .overflow(a_ovf), .underflow(a_unf), .clr_err(clr_err)
  );

  fifo_flex #(.B(8), .W(2), .FWFT(0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(b_rdata), .r_valid(b_rvalid), .empty(b_empty), .full(b_full),
    .almost_empty(b_ae), .almost_full(b_af), .count(b_count),
    .overflow(b_ovf), .underflow(b_unf), .clr_err(clr_err)
  );

  typedef struct {
    logic       wr, rd, fl, clr;
    logic [7:0] wd;
    int         cnt;
    logic       ovf, unf;
    logic       chk_d;
    logic [7:0] rdat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic w, logic r, logic f, logic c, logic [7:0] d,
                              int n, logic o, logic u, logic cd, logic [7:0] rdt);
    vec_t v;
    v.wr = w; v.rd = r; v.fl = f; v.clr = c; v.wd = d;
    v.cnt = n; v.ovf = o; v.unf = u; v.chk_d = cd; v.rdat = rdt;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rs, input logic w, input logic r, input logic f,
                       input logic c, input logic [7:0] d);
    @(negedge clk);
    reset = rs; wr = w; rd = r; flush = f; clr_err = c; w_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " a_count"}, int'(a_count), 0);
    chk({tag, " a_empty"}, int'(a_empty), 1);
    chk({tag, " a_full"},  int'(a_full), 0);
    chk({tag, " a_ae"},    int'(a_ae), 1);
    chk({tag, " a_af"},    int'(a_af), 0);
    chk({tag, " a_ovf"},   int'(a_ovf), 0);
    chk({tag, " a_unf"},   int'(a_unf), 0);
    chk({tag, " a_rvalid"}, int'(a_rvalid), 0);
    chk({tag, " b_count"}, int'(b_count), 0);
    chk({tag, " b_rvalid"}, int'(b_rvalid), 0);
    chk({tag, " b_rdata"}, int'(b_rdata), 0);
    chk({tag, " b_unf"},   int'(b_unf), 0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; w_data = 8'h00;

    // Fill order, overflow, drain (AF=2, AE=1, depth 4)
    tbl.push_back(mk(1,0,0,0,8'h11, 1,0,0, 1,8'h11));
    tbl.push_back(mk(1,0,0,0,8'h22, 2,0,0, 1,8'h11));
    tbl.push_back(mk(1,0,0,0,8'h33, 3,0,0, 1,8'h11));
    tbl.push_back(mk(1,0,0,0,8'h44, 4,0,0, 1,8'h11));
    tbl.push_back(mk(1,0,0,0,8'h99, 4,1,0, 1,8'h11));
    tbl.push_back(mk(0,1,0,0,8'h00, 3,1,0, 1,8'h22));
    tbl.push_back(mk(0,1,0,0,8'h00, 2,1,0, 1,8'h33));
    tbl.push_back(mk(0,1,0,0,8'h00, 1,1,0, 1,8'h44));
    tbl.push_back(mk(0,1,0,0,8'h00, 0,1,0, 0,8'h00));
    tbl.push_back(mk(0,0,0,1,8'h00, 0,0,0, 0,8'h00));
    // Interleaved traffic wrapping both pointers
    tbl.push_back(mk(1,0,0,0,8'hA0, 1,0,0, 1,8'hA0));
    tbl.push_back(mk(1,0,0,0,8'hA1, 2,0,0, 1,8'hA0));
    tbl.push_back(mk(1,1,0,0,8'hA2, 2,0,0, 1,8'hA1));
    tbl.push_back(mk(1,1,0,0,8'hA3, 2,0,0, 1,8'hA2));
    tbl.push_back(mk(1,1,0,0,8'hA4, 2,0,0, 1,8'hA3));
    tbl.push_back(mk(1,1,0,0,8'hA5, 2,0,0, 1,8'hA4));
    tbl.push_back(mk(0,1,0,0,8'h00, 1,0,0, 1,8'hA5));
    tbl.push_back(mk(0,1,0,0,8'h00, 0,0,0, 0,8'h00));
    // Simultaneous read/write while full
    tbl.push_back(mk(1,0,0,0,8'hB0, 1,0,0, 1,8'hB0));
    tbl.push_back(mk(1,0,0,0,8'hB1, 2,0,0, 1,8'hB0));
    tbl.push_back(mk(1,0,0,0,8'hB2, 3,0,0, 1,8'hB0));
    tbl.push_back(mk(1,0,0,0,8'hB3, 4,0,0, 1,8'hB0));
    tbl.push_back(mk(1,1,0,0,8'h55, 4,0,0, 1,8'hB1));
    tbl.push_back(mk(0,1,0,0,8'h00, 3,0,0, 1,8'hB2));
    tbl.push_back(mk(0,1,0,0,8'h00, 2,0,0, 1,8'hB3));
    tbl.push_back(mk(0,1,0,0,8'h00, 1,0,0, 1,8'h55));
    tbl.push_back(mk(0,1,0,0,8'h00, 0,0,0, 0,8'h00));
    // Simultaneous read/write while empty, then clear
    tbl.push_back(mk(1,1,0,0,8'h77, 1,0,1, 1,8'h77));
    tbl.push_back(mk(0,0,0,1,8'h00, 1,0,0, 1,8'h77));
    tbl.push_back(mk(0,1,0,0,8'h00, 0,0,0, 0,8'h00));
    // Flush with same-cycle write / read: ignored, no error effects
    tbl.push_back(mk(1,0,0,0,8'hC0, 1,0,0, 1,8'hC0));
    tbl.push_back(mk(1,0,0,0,8'hC1, 2,0,0, 1,8'hC0));
    tbl.push_back(mk(1,0,0,0,8'hC2, 3,0,0, 1,8'hC0));
    tbl.push_back(mk(1,0,1,0,8'hDD, 0,0,0, 0,8'h00));
    tbl.push_back(mk(0,1,1,0,8'h00, 0,0,0, 0,8'h00));
    // Flush keeps a pending overflow; storage restarts at slot 0
    tbl.push_back(mk(1,0,0,0,8'hE0, 1,0,0, 1,8'hE0));
    tbl.push_back(mk(1,0,0,0,8'hE1, 2,0,0, 1,8'hE0));
    tbl.push_back(mk(1,0,0,0,8'hE2, 3,0,0, 1,8'hE0));
    tbl.push_back(mk(1,0,0,0,8'hE3, 4,0,0, 1,8'hE0));
    tbl.push_back(mk(1,0,0,0,8'hEE, 4,1,0, 1,8'hE0));
    tbl.push_back(mk(0,0,1,0,8'h00, 0,1,0, 0,8'h00));
    tbl.push_back(mk(0,0,0,1,8'h00, 0,0,0, 0,8'h00));
    tbl.push_back(mk(1,0,0,0,8'hF1, 1,0,0, 1,8'hF1));
    tbl.push_back(mk(0,1,0,0,8'h00, 0,0,0, 0,8'h00));

    drive(1,0,0,0,0,8'h00);
    drive(1,0,0,0,0,8'h00);
    chk_reset_state("reset");

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(0, tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].clr, tbl[i].wd);
      chk({tag, " count"},  int'(a_count), tbl[i].cnt);
      chk({tag, " empty"},  int'(a_empty), int'(tbl[i].cnt == 0));
      chk({tag, " full"},   int'(a_full),  int'(tbl[i].cnt == 4));
      chk({tag, " af"},     int'(a_af),    int'(tbl[i].cnt >= 2));
      chk({tag, " ae"},     int'(a_ae),    int'(tbl[i].cnt <= 1));
      chk({tag, " ovf"},    int'(a_ovf),   int'(tbl[i].ovf));
      chk({tag, " unf"},    int'(a_unf),   int'(tbl[i].unf));
      chk({tag, " rvalid"}, int'(a_rvalid), int'(tbl[i].cnt != 0));
      if (tbl[i].chk_d) chk({tag, " rdata"}, int'(a_rdata), int'(tbl[i].rdat));
    end

    // Reset in the middle of a burst discards contents and error state
    drive(0,0,1,0,0,8'h00);
    chk("pre-reset a_unf", int'(a_unf), 1);
    drive(0,1,0,0,0,8'h31);
    drive(0,1,0,0,0,8'h32);
    chk("pre-reset a_count", int'(a_count), 2);
    drive(1,1,0,0,0,8'h33);
    chk_reset_state("midburst");

    // Registered read mode: one-cycle latency, one-cycle strobe, data holds
    drive(0,1,0,0,0,8'h5A);
    drive(0,1,0,0,0,8'hC3);
    chk("reg idle rvalid", int'(b_rvalid), 0);
    chk("reg idle rdata", int'(b_rdata), 0);
    chk("reg count", int'(b_count), 2);
    drive(0,0,1,0,0,8'h00);
    chk("reg rd1 rvalid", int'(b_rvalid), 1);
    chk("reg rd1 rdata", int'(b_rdata), 'h5A);
    drive(0,0,1,0,0,8'h00);
    chk("reg rd2 rvalid", int'(b_rvalid), 1);
    chk("reg rd2 rdata", int'(b_rdata), 'hC3);
    drive(0,0,0,0,0,8'h00);
    chk("reg done rvalid", int'(b_rvalid), 0);
    chk("reg hold rdata", int'(b_rdata), 'hC3);
    chk("reg empty", int'(b_empty), 1);

    // Registered mode: flush on the edge of a read suppresses the strobe
    drive(0,1,0,0,0,8'h66);
    drive(0,0,1,1,0,8'h00);
    chk("reg flush rvalid", int'(b_rvalid), 0);
    chk("reg flush rdata", int'(b_rdata), 'hC3);
    chk("reg flush count", int'(b_count), 0);
    drive(0,0,1,0,0,8'h00);
    chk("reg empty-rd rvalid", int'(b_rvalid), 0);
    chk("reg empty-rd unf", int'(b_unf), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
